// File: rtl/match_controller.sv
// match_controller: sequences the card-dealing state machine through a
// best-of-N match. It holds the dealer in reset between rounds, releases it
// to play, tallies round results from the two win lights, and declares the
// match winner. Supports pause at round boundaries, abort, and a watchdog
// fault for rounds that never produce a result.
module match_controller #(
    parameter int CW         = 4,
    parameter int WIN_TARGET = 5,
    parameter int MAX_ROUNDS = 9,
    parameter int TIMEOUT    = 12
) (
    input  logic          slow_clock,
    input  logic          resetb,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    input  logic          player_win_light,
    input  logic          dealer_win_light,
    output logic          sm_resetb,
    output logic [CW-1:0] player_tally,
    output logic [CW-1:0] dealer_tally,
    output logic [CW-1:0] tie_tally,
    output logic [CW-1:0] round_count,
    output logic          match_over,
    output logic          match_player_win,
    output logic          match_dealer_win,
    output logic          fault
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PLAY,
        HOLD,
        DONE,
        FAULT
    } state_t;

    state_t          state;
    logic            start_q;
    logic [TW-1:0]   tmo_count;

    logic            start_rise;
    logic            strobe;
    logic            is_player;
    logic            is_dealer;
    logic            is_tie;
    logic [CW-1:0]   p_next;
    logic [CW-1:0]   d_next;
    logic [CW-1:0]   t_next;
    logic [CW-1:0]   r_next;
    logic            match_end;

    assign start_rise = start & ~start_q;
    assign strobe     = player_win_light | dealer_win_light;
    assign is_tie     = player_win_light & dealer_win_light;
    assign is_player  = player_win_light & ~dealer_win_light;
    assign is_dealer  = dealer_win_light & ~player_win_light;

    // Post-increment tally values for the round being reported this cycle,
    // so the end-of-match decision sees the counts including this round.
    always_comb begin
        p_next    = player_tally + {{(CW-1){1'b0}}, is_player};
        d_next    = dealer_tally + {{(CW-1){1'b0}}, is_dealer};
        t_next    = tie_tally + {{(CW-1){1'b0}}, is_tie};
        r_next    = round_count + {{(CW-1){1'b0}}, 1'b1};
        match_end = (p_next == CW'(WIN_TARGET)) ||
                    (d_next == CW'(WIN_TARGET)) ||
                    (r_next == CW'(MAX_ROUNDS));
    end

    // Match sequencer: state, counters and all registered outputs.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state            <= IDLE;
            start_q          <= 1'b0;
            tmo_count        <= '0;
            sm_resetb        <= 1'b0;
            player_tally     <= '0;
            dealer_tally     <= '0;
            tie_tally        <= '0;
            round_count      <= '0;
            match_over       <= 1'b0;
            match_player_win <= 1'b0;
            match_dealer_win <= 1'b0;
            fault            <= 1'b0;
        end else begin
            start_q <= start;
            if (abort) begin
                state            <= IDLE;
                tmo_count        <= '0;
                sm_resetb        <= 1'b0;
                player_tally     <= '0;
                dealer_tally     <= '0;
                tie_tally        <= '0;
                round_count      <= '0;
                match_over       <= 1'b0;
                match_player_win <= 1'b0;
                match_dealer_win <= 1'b0;
                fault            <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE, FAULT: begin
                        if (start_rise) begin
                            state            <= ARM;
                            sm_resetb        <= 1'b1;
                            player_tally     <= '0;
                            dealer_tally     <= '0;
                            tie_tally        <= '0;
                            round_count      <= '0;
                            match_over       <= 1'b0;
                            match_player_win <= 1'b0;
                            match_dealer_win <= 1'b0;
                            fault            <= 1'b0;
                        end
                    end
                    ARM: begin
                        state     <= PLAY;
                        sm_resetb <= 1'b1;
                        tmo_count <= '0;
                    end
                    PLAY: begin
                        if (strobe) begin
                            player_tally <= p_next;
                            dealer_tally <= d_next;
                            tie_tally    <= t_next;
                            round_count  <= r_next;
                            tmo_count    <= '0;
                            if (match_end) begin
                                state            <= DONE;
                                sm_resetb        <= 1'b0;
                                match_over       <= 1'b1;
                                match_player_win <= (p_next >= d_next);
                                match_dealer_win <= (d_next >= p_next);
                            end else if (pause) begin
                                state     <= HOLD;
                                sm_resetb <= 1'b0;
                            end
                        end else if (tmo_count == TW'(TIMEOUT - 1)) begin
                            state     <= FAULT;
                            sm_resetb <= 1'b0;
                            fault     <= 1'b1;
                            tmo_count <= TW'(TIMEOUT);
                        end else begin
                            tmo_count <= tmo_count + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end
                    HOLD: begin
                        if (!pause) begin
                            state     <= ARM;
                            sm_resetb <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        sm_resetb <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: scoreboard bench for match_controller. Expected
// outputs come from a small behavioural model, are queued when stimulus is
// driven, and are popped and compared once the DUT has had its clock edge.
module tb_match_controller;

    localparam int CW = 4;

    // Model states
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_DONE  = 3;
    localparam int M_FAULT = 4;

    typedef struct packed {
        logic [CW-1:0] p;
        logic [CW-1:0] d;
        logic [CW-1:0] t;
        logic [CW-1:0] r;
        logic          smr;
        logic          over;
        logic          pw;
        logic          dw;
        logic          flt;
    } exp_t;

    logic          slow_clock;
    logic          resetb;
    logic          start;
    logic          pause;
    logic          abort;
    logic          player_win_light;
    logic          dealer_win_light;
    logic          sm_resetb;
    logic [CW-1:0] player_tally;
    logic [CW-1:0] dealer_tally;
    logic [CW-1:0] tie_tally;
    logic [CW-1:0] round_count;
    logic          match_over;
    logic          match_player_win;
    logic          match_dealer_win;
    logic          fault;

    int   n_compared;
    int   n_mismatched;
    exp_t sb_q[$];

    int   m_p, m_d, m_t, m_r, m_state;
    logic m_smr, m_over, m_pw, m_dw, m_flt;

    match_controller #(
        .CW(CW), .WIN_TARGET(5), .MAX_ROUNDS(9), .TIMEOUT(12)
    ) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start            (start),
        .pause            (pause),
        .abort            (abort),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .sm_resetb        (sm_resetb),
        .player_tally     (player_tally),
        .dealer_tally     (dealer_tally),
        .tie_tally        (tie_tally),
        .round_count      (round_count),
        .match_over       (match_over),
        .match_player_win (match_player_win),
        .match_dealer_win (match_dealer_win),
        .fault            (fault)
    );

    // Free-running slow clock
    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Global time bound so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        m_p = 0; m_d = 0; m_t = 0; m_r = 0;
        m_over = 1'b0; m_pw = 1'b0; m_dw = 1'b0; m_flt = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.p    = CW'(m_p);
        e.d    = CW'(m_d);
        e.t    = CW'(m_t);
        e.r    = CW'(m_r);
        e.smr  = m_smr;
        e.over = m_over;
        e.pw   = m_pw;
        e.dw   = m_dw;
        e.flt  = m_flt;
        sb_q.push_back(e);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_output({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_output({tag, "_player_tally"}, 32'(player_tally), 32'(e.p));
            check_output({tag, "_dealer_tally"}, 32'(dealer_tally), 32'(e.d));
            check_output({tag, "_tie_tally"}, 32'(tie_tally), 32'(e.t));
            check_output({tag, "_round_count"}, 32'(round_count), 32'(e.r));
            check_output({tag, "_sm_resetb"}, 32'(sm_resetb), 32'(e.smr));
            check_output({tag, "_match_over"}, 32'(match_over), 32'(e.over));
            check_output({tag, "_player_win"}, 32'(match_player_win), 32'(e.pw));
            check_output({tag, "_dealer_win"}, 32'(match_dealer_win), 32'(e.dw));
            check_output({tag, "_fault"}, 32'(fault), 32'(e.flt));
        end
    endtask

    // Behavioural model of one sampled cycle carrying lights and/or abort
    task automatic model_update(input logic pl, input logic dl, input logic ab);
        if (ab) begin
            model_clear();
            m_state = M_IDLE;
            m_smr   = 1'b0;
        end else if ((pl || dl) && m_state == M_PLAY) begin
            m_r++;
            if (pl && dl)  m_t++;
            else if (pl)   m_p++;
            else           m_d++;
            if (m_p == 5 || m_d == 5 || m_r == 9) begin
                m_state = M_DONE;
                m_smr   = 1'b0;
                m_over  = 1'b1;
                m_pw    = (m_p >= m_d);
                m_dw    = (m_d >= m_p);
            end else if (pause) begin
                m_state = M_HOLD;
                m_smr   = 1'b0;
            end
        end
    endtask

    // Idle for gap cycles, then present one cycle of lights/abort and score it
    task automatic apply_stimulus(input logic pl, input logic dl, input logic ab,
                                  input int gap, input string tag);
        repeat (gap) @(negedge slow_clock);
        player_win_light = pl;
        dealer_win_light = dl;
        abort            = ab;
        model_update(pl, dl, ab);
        push_expected();
        @(negedge slow_clock);
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        abort            = 1'b0;
        compare_outputs(tag);
    endtask

    // Rising edge on start: DUT goes to ARM with counts cleared
    task automatic start_match(input string tag);
        start = 1'b1;
        model_clear();
        m_smr = 1'b1;
        push_expected();
        @(negedge slow_clock);
        start = 1'b0;
        compare_outputs(tag);
        m_state = M_PLAY;
    endtask

    task automatic expect_after(input int ncycles, input string tag);
        push_expected();
        repeat (ncycles) @(negedge slow_clock);
        compare_outputs(tag);
    endtask

    // Main stimulus sequence
    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        resetb           = 1'b0;
        start            = 1'b0;
        pause            = 1'b0;
        abort            = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        model_clear();
        m_state = M_IDLE;
        m_smr   = 1'b0;

        #2;
        push_expected();
        compare_outputs("reset");
        @(negedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
        expect_after(2, "idle");

        // Async reset mid-PLAY with tallies 2/1/0
        start_match("startA");
        apply_stimulus(1'b1, 1'b0, 1'b0, 6, "A_r1");
        apply_stimulus(1'b0, 1'b1, 1'b0, 6, "A_r2");
        apply_stimulus(1'b1, 1'b0, 1'b0, 6, "A_r3");
        #2;
        resetb = 1'b0;
        model_clear();
        m_state = M_IDLE;
        m_smr   = 1'b0;
        push_expected();
        #1;
        compare_outputs("async_reset");
        @(negedge slow_clock);
        resetb = 1'b1;
        @(negedge slow_clock);

        // Five straight player wins, strobes 7 cycles apart
        start_match("startB");
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 6, $sformatf("B_r%0d", i + 1));
        apply_stimulus(1'b0, 1'b1, 1'b0, 3, "B_done_ignore");

        // Nine rounds P,D,tie ending drawn on round count
        start_match("startC");
        for (int i = 0; i < 9; i++)
            apply_stimulus((i % 3) != 1, (i % 3) != 0, 1'b0, 6 + (i % 3),
                           $sformatf("C_r%0d", i + 1));

        // Pause taken on the second strobe
        start_match("startD");
        apply_stimulus(1'b1, 1'b0, 1'b0, 6, "D_r1");
        pause = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 6, "D_r2_hold");
        apply_stimulus(1'b1, 1'b0, 1'b0, 2, "D_hold_ignore");
        pause = 1'b0;
        m_smr = 1'b1;
        expect_after(1, "D_hold_release");
        m_state = M_PLAY;

        // No strobe in PLAY: watchdog fault on the 12th PLAY cycle
        expect_after(12, "E_tmo_wait");
        m_state = M_FAULT;
        m_smr   = 1'b0;
        m_flt   = 1'b1;
        expect_after(1, "E_tmo_fault");
        apply_stimulus(1'b0, 1'b1, 1'b0, 2, "E_fault_ignore");
        start_match("E_restart");

        // Abort alongside a dealer strobe at dealer_tally 4
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b0, 1'b1, 1'b0, 6, $sformatf("F_r%0d", i + 1));
        apply_stimulus(1'b0, 1'b1, 1'b1, 6, "F_abort");
        apply_stimulus(1'b1, 1'b0, 1'b0, 2, "F_idle_ignore");

        check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
